// File: rtl/bp_ctable_ctrl.sv
// Port sequencer for the bimodal predictor counter table held in a single-port RAM.
// Clears the table, queues EX resolutions, and interleaves lookups with counter RMW updates.
module bp_ctable_ctrl #(
    parameter int CTableSize   = 512,
    parameter int CounterLen   = 4,
    parameter int UpdFifoDepth = 4,
    parameter int MaxStall     = 4,
    localparam int IDXW        = $clog2(CTableSize)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  ready_o,
    input  logic                  lookup_req_i,
    input  logic [31:0]           lookup_pc_i,
    output logic                  lookup_ready_o,
    output logic                  lookup_valid_o,
    output logic                  lookup_taken_o,
    input  logic                  ex_br_valid_i,
    input  logic [31:0]           ex_br_instr_addr_i,
    input  logic                  ex_br_taken_i,
    output logic                  upd_drop_o,
    output logic                  tbl_req_o,
    output logic                  tbl_we_o,
    output logic [IDXW-1:0]       tbl_addr_o,
    output logic [CounterLen-1:0] tbl_wdata_o,
    input  logic [CounterLen-1:0] tbl_rdata_i
);

    localparam int PTRW = $clog2(UpdFifoDepth);
    localparam int SCW  = $clog2(MaxStall + 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    localparam logic [CounterLen-1:0] CntMax = {1'b0, {(CounterLen-1){1'b1}}};
    localparam logic [CounterLen-1:0] CntMin = {1'b1, {(CounterLen-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [IDXW-1:0]       initIdx_q, initIdx_d;
    logic [SCW-1:0]        stallCnt_q, stallCnt_d;
    logic [CounterLen-1:0] cnt_q, cnt_d;
    logic                  lookupValid_q, lookupInit_q;

    logic [IDXW:0]         fifoMem_q [UpdFifoDepth];
    logic [PTRW:0]         wrPtr_q, rdPtr_q;

    logic                  fifoEmpty, fifoFull, pushReq, pushOk, pop;
    logic [IDXW-1:0]       lookupIdx, exIdx, headIdx;
    logic                  headTaken, lookupAcc;
    logic [CounterLen-1:0] satNext;
    logic                  unusedPcBits;

    assign lookupIdx    = lookup_pc_i[IDXW+1:2];
    assign exIdx        = ex_br_instr_addr_i[IDXW+1:2];
    assign unusedPcBits = ^{lookup_pc_i[31:IDXW+2], lookup_pc_i[1:0],
                            ex_br_instr_addr_i[31:IDXW+2], ex_br_instr_addr_i[1:0]};

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = ((wrPtr_q - rdPtr_q) == (PTRW+1)'(UpdFifoDepth));
    assign {headIdx, headTaken} = fifoMem_q[rdPtr_q[PTRW-1:0]];

    assign ready_o        = (state_q != ST_INIT);
    assign lookup_ready_o = !((state_q == ST_WR) && (stallCnt_q == SCW'(MaxStall)));
    assign lookupAcc      = lookup_req_i && lookup_ready_o;
    assign lookup_valid_o = lookupValid_q;
    assign lookup_taken_o = lookupValid_q && (lookupInit_q || !tbl_rdata_i[CounterLen-1]);

    // Updates arriving while the table is being cleared are meaningless and vanish without a drop pulse.
    assign pushReq    = ex_br_valid_i && (state_q != ST_INIT) && !flush_i;
    assign pushOk     = pushReq && (!fifoFull || pop);
    assign upd_drop_o = pushReq && fifoFull && !pop;

    assign satNext = headTaken ? ((cnt_q == CntMax) ? cnt_q : cnt_q + CounterLen'(1))
                               : ((cnt_q == CntMin) ? cnt_q : cnt_q - CounterLen'(1));

    always_comb begin
        state_d     = state_q;
        initIdx_d   = initIdx_q;
        stallCnt_d  = stallCnt_q;
        cnt_d       = cnt_q;
        tbl_req_o   = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = lookupIdx;
        tbl_wdata_o = '0;
        pop         = 1'b0;
        case (state_q)
            ST_INIT: begin
                tbl_req_o  = 1'b1;
                tbl_we_o   = 1'b1;
                tbl_addr_o = initIdx_q;
                initIdx_d  = initIdx_q + IDXW'(1);
                if (initIdx_q == IDXW'(CTableSize - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (lookupAcc) begin
                    tbl_req_o = 1'b1;
                end else if (!fifoEmpty && !flush_i) begin
                    tbl_req_o  = 1'b1;
                    tbl_addr_o = headIdx;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                cnt_d      = tbl_rdata_i;
                stallCnt_d = '0;
                state_d    = ST_WR;
                tbl_req_o  = lookupAcc;
            end
            ST_WR: begin
                // A flush here abandons the RMW so the stale counter never reaches the table.
                if (lookupAcc) begin
                    tbl_req_o  = 1'b1;
                    stallCnt_d = stallCnt_q + SCW'(1);
                end else if (!flush_i) begin
                    tbl_req_o   = 1'b1;
                    tbl_we_o    = 1'b1;
                    tbl_addr_o  = headIdx;
                    tbl_wdata_o = satNext;
                    pop         = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (flush_i) begin
            state_d   = ST_INIT;
            initIdx_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_INIT;
            initIdx_q     <= '0;
            stallCnt_q    <= '0;
            cnt_q         <= '0;
            lookupValid_q <= 1'b0;
            lookupInit_q  <= 1'b0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
        end else begin
            state_q       <= state_d;
            initIdx_q     <= initIdx_d;
            stallCnt_q    <= stallCnt_d;
            cnt_q         <= cnt_d;
            lookupValid_q <= lookupAcc;
            lookupInit_q  <= (state_q == ST_INIT);
            if (flush_i) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
            end else begin
                if (pushOk) wrPtr_q <= wrPtr_q + (PTRW+1)'(1);
                if (pop)    rdPtr_q <= rdPtr_q + (PTRW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q[PTRW-1:0]] <= {exIdx, ex_br_taken_i};
        end
    end

endmodule

// File: tb/tb_bp_ctable_ctrl.sv
// Directed bench for bp_ctable_ctrl: a behavioural single-port RAM sits behind the table port
// and every expected value below is worked out by hand from the counter/FIFO/arbitration rules.
module tb_bp_ctable_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        ready_o;
    logic        lookup_req_i;
    logic [31:0] lookup_pc_i;
    logic        lookup_ready_o, lookup_valid_o, lookup_taken_o;
    logic        ex_br_valid_i;
    logic [31:0] ex_br_instr_addr_i;
    logic        ex_br_taken_i;
    logic        upd_drop_o;
    logic        tbl_req_o, tbl_we_o;
    logic [8:0]  tbl_addr_o;
    logic [3:0]  tbl_wdata_o;
    logic [3:0]  tbl_rdata_i;

    logic [3:0]  ram [512];
    int          compared   = 0;
    int          mismatched = 0;

    bp_ctable_ctrl dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .ready_o            (ready_o),
        .lookup_req_i       (lookup_req_i),
        .lookup_pc_i        (lookup_pc_i),
        .lookup_ready_o     (lookup_ready_o),
        .lookup_valid_o     (lookup_valid_o),
        .lookup_taken_o     (lookup_taken_o),
        .ex_br_valid_i      (ex_br_valid_i),
        .ex_br_instr_addr_i (ex_br_instr_addr_i),
        .ex_br_taken_i      (ex_br_taken_i),
        .upd_drop_o         (upd_drop_o),
        .tbl_req_o          (tbl_req_o),
        .tbl_we_o           (tbl_we_o),
        .tbl_addr_o         (tbl_addr_o),
        .tbl_wdata_o        (tbl_wdata_o),
        .tbl_rdata_i        (tbl_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk_i) begin
        if (tbl_req_o) begin
            if (tbl_we_o) ram[tbl_addr_o] <= tbl_wdata_o;
            else          tbl_rdata_i     <= ram[tbl_addr_o];
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled just after the falling edge.
    task automatic cyc();
        @(negedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic lkReq, input logic [31:0] lkPc,
                                 input logic exV, input logic [31:0] exPc, input logic exT);
        lookup_req_i       = lkReq;
        lookup_pc_i        = lkPc;
        ex_br_valid_i      = exV;
        ex_br_instr_addr_i = exPc;
        ex_br_taken_i      = exT;
        #1;
    endtask

    task automatic waitInit(input int startIdx);
        int n   = startIdx;
        int bad = 0;
        int cnt = 0;
        while (!ready_o && cnt < 1000) begin
            if (!(tbl_req_o && tbl_we_o && tbl_addr_o == 9'(n) && tbl_wdata_o == 4'd0)) bad++;
            n++;
            cnt++;
            cyc();
        end
        checkOutput("init_write_count", n, 512);
        checkOutput("init_bad_writes", bad, 0);
        checkOutput("ready_after_init", ready_o, 1'b1);
    endtask

    task automatic sendUpdate(input logic [31:0] pc, input logic taken);
        applyStimulus(1'b0, 32'h0, 1'b1, pc, taken);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (4) cyc();
    endtask

    initial begin
        int drops;
        int idleReq;
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #12;
        checkOutput("rst_ready", ready_o, 1'b0);
        checkOutput("rst_lookup_valid", lookup_valid_o, 1'b0);
        checkOutput("rst_upd_drop", upd_drop_o, 1'b0);
        checkOutput("rst_tbl_we", {tbl_req_o, tbl_we_o}, 2'b11);
        checkOutput("rst_tbl_addr", tbl_addr_o, 9'd0);
        checkOutput("rst_tbl_wdata", tbl_wdata_o, 4'd0);

        // 1: full clear after reset release
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        waitInit(0);

        // 2: saturation at +7 and -8 on index 64
        for (int i = 0; i < 8; i++) sendUpdate(32'h100, 1'b1);
        checkOutput("ram64_sat_pos", ram[64], 4'h7);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        checkOutput("lk_pos_accept", {lookup_ready_o, tbl_req_o, tbl_we_o}, 3'b110);
        checkOutput("lk_pos_addr", tbl_addr_o, 9'd64);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("lk_pos_result", {lookup_valid_o, lookup_taken_o}, 2'b11);
        cyc();
        for (int i = 0; i < 16; i++) sendUpdate(32'h100, 1'b0);
        checkOutput("ram64_sat_neg", ram[64], 4'h8);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("lk_neg_result", {lookup_valid_o, lookup_taken_o}, 2'b10);
        cyc();

        // 3: seven back-to-back pushes; only the 6th finds the FIFO full with no pop
        drops = 0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'((i + 1) * 4), 1'b1);
            checkOutput($sformatf("drop_c%0d", i), upd_drop_o, (i == 5));
            if (upd_drop_o) drops++;
            cyc();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("drop_total", drops, 1);
        repeat (20) cyc();
        checkOutput("ram1_updated", ram[1], 4'h1);
        checkOutput("ram5_updated", ram[5], 4'h1);
        checkOutput("ram6_dropped", ram[6], 4'h0);
        checkOutput("ram7_updated", ram[7], 4'h1);

        // 4: lookups held through an RMW defer the write by MaxStall cycles
        applyStimulus(1'b0, 32'h0, 1'b1, 32'd40, 1'b1);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rmw_read", {tbl_req_o, tbl_we_o, 23'(tbl_addr_o)}, {2'b10, 23'd10});
        cyc();
        applyStimulus(1'b1, 32'd80, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("stall_ready_c%0d", i), lookup_ready_o, (i != 5));
            checkOutput($sformatf("stall_we_c%0d", i), {tbl_req_o, tbl_we_o}, {1'b1, (i == 5)});
            if (i == 5) checkOutput("forced_write", {tbl_addr_o, tbl_wdata_o}, {9'd10, 4'd1});
            if (i == 1) checkOutput("stall_lk_result", {lookup_valid_o, lookup_taken_o}, 2'b11);
            cyc();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("ram10_after_stall", ram[10], 4'h1);

        // 5: flush during WR abandons the write, clears the queue and restarts the clear
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h30, 1'b1);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h34, 1'b1);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        flush_i = 1'b1;
        #1;
        checkOutput("flush_no_write", tbl_req_o, 1'b0);
        cyc();
        flush_i = 1'b0;
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
        checkOutput("reinit_ready", ready_o, 1'b0);
        checkOutput("reinit_first", {tbl_req_o, tbl_we_o, 23'(tbl_addr_o)}, {2'b11, 23'd0});
        checkOutput("init_lk_ready", lookup_ready_o, 1'b1);
        checkOutput("init_silent_drop", upd_drop_o, 1'b0);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("init_lk_result", {lookup_valid_o, lookup_taken_o}, 2'b11);
        checkOutput("reinit_second", tbl_addr_o, 9'd1);
        waitInit(1);
        idleReq = 0;
        repeat (6) begin
            if (tbl_req_o) idleReq++;
            cyc();
        end
        checkOutput("fifo_empty_after_flush", idleReq, 0);

        // 6: asynchronous reset in the middle of an RMW
        applyStimulus(1'b0, 32'h0, 1'b1, 32'd120, 1'b1);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        cyc();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_reset_valid", lookup_valid_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_valid", lookup_valid_o, 1'b0);
        checkOutput("async_ready", ready_o, 1'b0);
        checkOutput("async_drop", upd_drop_o, 1'b0);
        checkOutput("async_port", {tbl_req_o, tbl_we_o, 23'(tbl_addr_o)}, {2'b11, 23'd0});
        cyc();
        cyc();
        rst_ni = 1'b1;
        #1;
        waitInit(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
